mult_operand_driver: RTL
========================

// Module: mult_operand_driver
// PURPOSE
//  Clocked initiator for a bundled-data 4-phase multiplier: buffers DEPTH (weight, input) pairs,
//  sends each pair on two operand channels, receives each product on one result channel,
//  and accumulates the products into a partial sum.
//  Sits between the PE load path and the multiplier; one accumulated sum is emitted per DEPTH pairs.
// PARAMETERS
//  WIDTH      8   operand and product width (the multiplier returns a product truncated to WIDTH)
//  DEPTH      5   pairs per accumulation; must be >= 1
//  ACC_WIDTH  16  accumulator / sum width
// PORTS
//  clk         in   1          single clock; all state updates on the rising edge
//  reset       in   1          asynchronous, active-high; clears all state
//  load_valid  in   1          load pair present
//  load_ready  out  1          driver accepts a pair this cycle
//  load_w      in   WIDTH      weight operand
//  load_x      in   WIDTH      input operand
//  op0_data    out  WIDTH      operand 0 (weight)
//  op0_req     out  1          operand 0 request
//  op0_ack     in   1          operand 0 acknowledge
//  op1_data    out  WIDTH      operand 1 (input)
//  op1_req     out  1          operand 1 request
//  op1_ack     in   1          operand 1 acknowledge
//  prod_data   in   WIDTH      product from the multiplier
//  prod_req    in   1          product request
//  prod_ack    out  1          product acknowledge
//  sum_data    out  ACC_WIDTH  accumulated sum
//  sum_valid   out  1          sum_data valid
//  sum_ready   in   1          consumer accepts the sum
// BEHAVIOUR
//  Reset
//   - All outputs are 0; state=LOAD; buffer, idx, cnt and acc are cleared.
//   - Reset asserted mid-handshake drops every req/ack immediately.
//   - The environment must be reset in the same window.
//  Handshake protocol (4-phase, both directions)
//   - Sender: data stable, then req=1.
//   - Receiver: ack=1.
//   - Sender: req=0.
//   - Receiver: ack=0.
//   - Data is held constant from the cycle before req rises until req falls.
//  States
//   - LOAD: load_ready=1. Each load_valid&&load_ready writes buf[cnt] and increments cnt.
//     When cnt reaches DEPTH: idx=0, go to SETUP.
//   - SETUP: op0_data=buf_w[idx], op1_data=buf_x[idx]. Go to SEND.
//   - SEND: op0_req=op1_req=1. Wait for both acks. Acks may arrive in different cycles; each ack is
//     latched individually. When both are latched, go to RELEASE.
//   - RELEASE: both reqs drop together. Wait until op0_ack=0 and op1_ack=0. Go to WAIT_PROD.
//   - WAIT_PROD: when prod_req=1, acc <= acc + zero-extended prod_data (wraps modulo 2^ACC_WIDTH);
//     prod_ack=1 in the next cycle. Go to PROD_DONE.
//     prod_req may rise while still in SEND or RELEASE; it is held by the protocol and serviced here.
//   - PROD_DONE: wait for prod_req=0, then prod_ack=0.
//     If idx==DEPTH-1 go to OUT; otherwise idx++ and go to SETUP.
//   - OUT: sum_data=acc, sum_valid=1 held until sum_ready. On the transfer: acc=0, cnt=0, go to LOAD.
//  Stalls
//   - load_valid outside LOAD is ignored, since load_ready=0.
//   - sum_ready held low stalls the driver indefinitely; sum_data stays stable.
//  Latency
//   - Minimum 6 cycles per pair after load, plus 1 cycle for OUT (without SYNC_EN, zero-delay environment).
// CONFIGURATION
//  SYNC_EN defined
//   - op0_ack, op1_ack and prod_req each pass through a 2-flop synchronizer before the FSM.
//   - prod_data is captured when the synchronized prod_req is seen.
//   - Each input edge adds 2 cycles of latency.
//  SYNC_EN undefined
//   - Those inputs are sampled directly.
//   - The environment must be synchronous to clk.
// TESTING
//  - DEPTH=3, pairs (2,5),(3,6),(4,7), responder returns w*x -> sum_data=56, sum_valid until sum_ready.
//  - Product truncation: pair (16,20), responder returns 8'd64 -> sum_data=64 (no extension beyond WIDTH).
//  - ACC_WIDTH=8, DEPTH=3, three products of 100 -> sum_data=44 (wrap).
//  - op1_ack rises 4 cycles after op0_ack -> reqs fall only after both acks; exactly one accumulate per pair.
//  - Reset asserted during SEND with op0_req=1 -> all outputs 0 the same cycle; a fresh load of 3 pairs completes correctly.
//  - sum_ready low for 10 cycles -> sum_valid=1 and sum_data stable; load_ready=0 until the transfer.
//    With SYNC_EN, per-pair latency increases by 6 cycles.

Source files
------------

// File: rtl/mult_operand_driver_if.sv
// Bundled-data channel group between the multiplier operand driver and its environment:
// load port, two operand request channels, one product channel and the sum output.
interface mult_operand_driver_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 load_valid;
    logic                 load_ready;
    logic [WIDTH-1:0]     load_w;
    logic [WIDTH-1:0]     load_x;

    logic [WIDTH-1:0]     op0_data;
    logic                 op0_req;
    logic                 op0_ack;
    logic [WIDTH-1:0]     op1_data;
    logic                 op1_req;
    logic                 op1_ack;

    logic [WIDTH-1:0]     prod_data;
    logic                 prod_req;
    logic                 prod_ack;

    logic [ACC_WIDTH-1:0] sum_data;
    logic                 sum_valid;
    logic                 sum_ready;

    // The driver side owns the requests on the operand channels and the acks on the product channel.
    modport master (
        input  load_valid, load_w, load_x,
        input  op0_ack, op1_ack, prod_data, prod_req, sum_ready,
        output load_ready, op0_data, op0_req, op1_data, op1_req, prod_ack, sum_data, sum_valid
    );

    modport slave (
        output load_valid, load_w, load_x,
        output op0_ack, op1_ack, prod_data, prod_req, sum_ready,
        input  load_ready, op0_data, op0_req, op1_data, op1_req, prod_ack, sum_data, sum_valid
    );
endinterface

// File: rtl/mult_operand_driver.sv
// Buffers DEPTH (weight, input) pairs, drives them through a 4-phase multiplier and accumulates
// the products. Define SYNC_EN to pass op0_ack, op1_ack and prod_req through 2-flop synchronizers.
module mult_operand_driver #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int ACC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mult_operand_driver_if.master  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SETUP,
        S_SEND,
        S_RELEASE,
        S_WAIT_PROD,
        S_PROD_DONE,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]     buf_w_q [DEPTH];
    logic [WIDTH-1:0]     buf_w_d [DEPTH];
    logic [WIDTH-1:0]     buf_x_q [DEPTH];
    logic [WIDTH-1:0]     buf_x_d [DEPTH];
    logic                 ack0_seen_q, ack0_seen_d;
    logic                 ack1_seen_q, ack1_seen_d;

    logic                 load_ready_q, load_ready_d;
    logic                 op_req_q, op_req_d;
    logic                 prod_ack_q, prod_ack_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [ACC_WIDTH-1:0] sum_data_q, sum_data_d;
    logic [WIDTH-1:0]     op0_data_q, op0_data_d;
    logic [WIDTH-1:0]     op1_data_q, op1_data_d;

    logic                 op0_ack_s, op1_ack_s, prod_req_s;

`ifdef SYNC_EN
    logic [1:0] op0_sync_q, op0_sync_d;
    logic [1:0] op1_sync_q, op1_sync_d;
    logic [1:0] prod_sync_q, prod_sync_d;

    always_comb begin
        op0_sync_d  = {op0_sync_q[0], bus.op0_ack};
        op1_sync_d  = {op1_sync_q[0], bus.op1_ack};
        prod_sync_d = {prod_sync_q[0], bus.prod_req};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op0_sync_q  <= '0;
            op1_sync_q  <= '0;
            prod_sync_q <= '0;
        end else begin
            op0_sync_q  <= op0_sync_d;
            op1_sync_q  <= op1_sync_d;
            prod_sync_q <= prod_sync_d;
        end
    end

    assign op0_ack_s  = op0_sync_q[1];
    assign op1_ack_s  = op1_sync_q[1];
    assign prod_req_s = prod_sync_q[1];
`else
    assign op0_ack_s  = bus.op0_ack;
    assign op1_ack_s  = bus.op1_ack;
    assign prod_req_s = bus.prod_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        buf_w_d     = buf_w_q;
        buf_x_d     = buf_x_q;
        ack0_seen_d = ack0_seen_q;
        ack1_seen_d = ack1_seen_q;

        case (state_q)
            S_LOAD: begin
                if (bus.load_valid && load_ready_q) begin
                    buf_w_d[cnt_q[IDX_W-1:0]] = bus.load_w;
                    buf_x_d[cnt_q[IDX_W-1:0]] = bus.load_x;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        idx_d   = '0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_SEND;
            S_SEND: begin
                // Acks may arrive in different cycles, so each one is remembered until both are in.
                ack0_seen_d = ack0_seen_q | op0_ack_s;
                ack1_seen_d = ack1_seen_q | op1_ack_s;
                if (ack0_seen_d && ack1_seen_d) begin
                    ack0_seen_d = 1'b0;
                    ack1_seen_d = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!op0_ack_s && !op1_ack_s) state_d = S_WAIT_PROD;
            end
            S_WAIT_PROD: begin
                if (prod_req_s) begin
                    acc_d   = acc_q + ACC_WIDTH'(bus.prod_data);
                    state_d = S_PROD_DONE;
                end
            end
            S_PROD_DONE: begin
                if (!prod_req_s) begin
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = S_OUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_OUT: begin
                if (bus.sum_ready && sum_valid_q) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Outputs are registered from the next state so reset forces every one of them low.
        load_ready_d = (state_d == S_LOAD);
        op_req_d     = (state_d == S_SEND);
        prod_ack_d   = (state_d == S_PROD_DONE);
        sum_valid_d  = (state_d == S_OUT);
        sum_data_d   = (state_d == S_OUT) ? acc_d : '0;
        op0_data_d   = op0_data_q;
        op1_data_d   = op1_data_q;
        if (state_d == S_SETUP) begin
            op0_data_d = buf_w_d[idx_d];
            op1_data_d = buf_x_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_w_q[i] <= '0;
                buf_x_q[i] <= '0;
            end
            ack0_seen_q  <= 1'b0;
            ack1_seen_q  <= 1'b0;
            load_ready_q <= 1'b0;
            op_req_q     <= 1'b0;
            prod_ack_q   <= 1'b0;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= '0;
            op0_data_q   <= '0;
            op1_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            buf_w_q      <= buf_w_d;
            buf_x_q      <= buf_x_d;
            ack0_seen_q  <= ack0_seen_d;
            ack1_seen_q  <= ack1_seen_d;
            load_ready_q <= load_ready_d;
            op_req_q     <= op_req_d;
            prod_ack_q   <= prod_ack_d;
            sum_valid_q  <= sum_valid_d;
            sum_data_q   <= sum_data_d;
            op0_data_q   <= op0_data_d;
            op1_data_q   <= op1_data_d;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.op0_data   = op0_data_q;
    assign bus.op1_data   = op1_data_q;
    assign bus.op0_req    = op_req_q;
    assign bus.op1_req    = op_req_q;
    assign bus.prod_ack   = prod_ack_q;
    assign bus.sum_data   = sum_data_q;
    assign bus.sum_valid  = sum_valid_q;
endmodule
